// File: rtl/arc4_engine.sv
// ARC4 (RC4) decryption engine with optional RC4-drop[N] keystream discard.
// Drives an external 256x8 S-box RAM, reads a length-prefixed ciphertext
// buffer and writes the length-prefixed plaintext buffer.
module arc4_engine #(
  parameter int KEY_BYTES = 3,
  parameter int DROP_N    = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic                   rdy,
  input  logic                   abort,
  output logic                   err,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             s_addr,
  output logic [7:0]             s_wrdata,
  output logic                   s_wren,
  input  logic [7:0]             s_rddata,
  output logic [7:0]             ct_addr,
  input  logic [7:0]             ct_rddata,
  output logic [7:0]             pt_addr,
  output logic [7:0]             pt_wrdata,
  output logic                   pt_wren
);

  typedef enum logic [2:0] {IDLE, INIT, KSA, LEN, DROP, PRGA} state_t;

  // Value of the drop counter on the last discarded byte.
  localparam logic [9:0] DROP_LAST = (DROP_N > 0) ? 10'(DROP_N - 1) : 10'd0;

  state_t                 state, state_nxt;
  logic [2:0]             phase;
  logic [7:0]             i, j, k, len, si_r, sj_r;
  logic [9:0]             dcnt;
  logic [8*KEY_BYTES-1:0] key_r;

  logic [7:0]             kbyte, ksa_j, prga_j;
  logic [8*KEY_BYTES-1:0] key_rot;

  // The key register rotates one byte per KSA step, so the top byte is
  // always key byte [i mod KEY_BYTES].
  assign kbyte   = key_r[8*KEY_BYTES-1 -: 8];
  assign key_rot = (key_r << 8) | (key_r >> (8*KEY_BYTES-8));
  assign ksa_j   = j + s_rddata + kbyte;
  assign prga_j  = j + s_rddata;
  assign rdy     = (state == IDLE);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort from any busy state returns to IDLE.
  always_comb begin
    // NOTE: the default assignment first keeps this block free of latches.
    state_nxt = state;
    case (state)
      IDLE: if (en && !abort) state_nxt = INIT;
      INIT: if (i == 8'hFF) state_nxt = KSA;
      KSA:  if (phase == 3'd3 && i == 8'hFF) state_nxt = LEN;
      LEN:  if (phase == 3'd1) begin
              if (DROP_N > 0)             state_nxt = DROP;
              else if (ct_rddata != 8'd0) state_nxt = PRGA;
              else                        state_nxt = IDLE;
            end
      DROP: if (phase == 3'd4 && dcnt == DROP_LAST)
              state_nxt = (len != 8'd0) ? PRGA : IDLE;
      PRGA: if (phase == 3'd5 && k == len) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && abort) state_nxt = IDLE;
  end

  // Datapath registers: indices, sub-cycle phase, captured S-box values, key.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i <= '0; j <= '0; k <= '0; phase <= '0; dcnt <= '0;
      len <= '0; si_r <= '0; sj_r <= '0; key_r <= '0; err <= 1'b0;
    end else if (state != IDLE && abort) begin
      i <= '0; j <= '0; k <= '0; phase <= '0; dcnt <= '0;
      err <= 1'b1;
    end else begin
      case (state)
        IDLE: if (en && !abort) begin
                key_r <= key;
                err   <= 1'b0;
                i <= '0; j <= '0; k <= '0; phase <= '0; dcnt <= '0;
              end
        INIT: i <= i + 8'd1;
        KSA: case (phase)
               3'd0: phase <= 3'd1;
               3'd1: begin si_r <= s_rddata; j <= ksa_j; phase <= 3'd2; end
               3'd2: begin sj_r <= s_rddata; phase <= 3'd3; end
               default: begin
                 i     <= i + 8'd1;
                 key_r <= key_rot;
                 phase <= 3'd0;
                 if (i == 8'hFF) j <= '0;
               end
             endcase
        LEN: if (phase == 3'd0) phase <= 3'd1;
             else begin
               len <= ct_rddata;
               phase <= '0; i <= '0; j <= '0; k <= 8'd1; dcnt <= '0;
             end
        DROP, PRGA: case (phase)
               3'd0: begin i <= i + 8'd1; phase <= 3'd1; end
               3'd1: begin si_r <= s_rddata; j <= prga_j; phase <= 3'd2; end
               3'd2: begin sj_r <= s_rddata; phase <= 3'd3; end
               3'd3: phase <= 3'd4;
               3'd4: if (state == DROP) begin
                       phase <= '0;
                       dcnt  <= dcnt + 10'd1;
                     end else phase <= 3'd5;
               default: begin phase <= '0; k <= k + 8'd1; end
             endcase
        default: ;
      endcase
    end
  end

  // Memory port outputs; writes are suppressed while aborting or in reset.
  always_comb begin
    s_addr = '0; s_wrdata = '0; s_wren = 1'b0;
    ct_addr = '0; pt_addr = '0; pt_wrdata = '0; pt_wren = 1'b0;
    case (state)
      INIT: begin s_addr = i; s_wrdata = i; s_wren = 1'b1; end
      KSA: case (phase)
             3'd0: s_addr = i;
             3'd1: s_addr = ksa_j;
             3'd2: begin s_addr = j; s_wrdata = si_r; s_wren = 1'b1; end
             default: begin s_addr = i; s_wrdata = sj_r; s_wren = 1'b1; end
           endcase
      LEN: if (phase == 3'd1) begin pt_wrdata = ct_rddata; pt_wren = 1'b1; end
      DROP, PRGA: begin
        if (state == PRGA) ct_addr = k;
        case (phase)
          3'd0: s_addr = i + 8'd1;
          3'd1: s_addr = prga_j;
          3'd2: begin s_addr = j; s_wrdata = si_r; s_wren = 1'b1; end
          3'd3: begin s_addr = i; s_wrdata = sj_r; s_wren = 1'b1; end
          3'd4: s_addr = si_r + sj_r;
          default: if (state == PRGA) begin
            pt_addr   = k;
            pt_wrdata = s_rddata ^ ct_rddata;
            pt_wren   = 1'b1;
          end
        endcase
      end
      default: ;
    endcase
    if (abort) begin
      s_wren  = 1'b0;
      pt_wren = 1'b0;
    end
    if (!rst_n) begin
      s_addr = '0; s_wrdata = '0; s_wren = 1'b0;
      ct_addr = '0; pt_addr = '0; pt_wrdata = '0; pt_wren = 1'b0;
    end
  end

endmodule

// File: tb/tb_arc4_engine.sv
// Directed bench for arc4_engine: three instances (3-byte key, 4-byte key,
// 3-byte key with drop[256]), each with its own S-box / ct / pt RAM models.
module tb_arc4_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  en_v = '0;
  logic [2:0]  abort_v = '0;
  logic [31:0] key_v [3];
  logic [7:0]  ct_mem [3][256];
  logic [7:0]  ks_exp [256];
  int          total = 0;
  int          bad = 0;
  int          lat, cnt, s0, p0;

  logic [7:0] ct31 [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  logic [7:0] pt31 [10] = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] ct32 [6]  = '{8'h05, 8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
  logic [7:0] pt32 [6]  = '{8'h05, 8'h70, 8'h65, 8'h64, 8'h69, 8'h61};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int KB = (g == 1) ? 4 : 3;
    localparam int DN = (g == 2) ? 256 : 0;
    logic [7:0] s_addr, s_wrdata, s_rddata, ct_addr, ct_rddata, pt_addr, pt_wrdata;
    logic       s_wren, pt_wren, rdy, err;
    logic [7:0] s_mem [256];
    logic [7:0] pt_mem [256];
    int         pt_writes = 0;
    int         s_writes = 0;
    int         both_hi = 0;

    arc4_engine #(.KEY_BYTES(KB), .DROP_N(DN)) dut (
      .clk(clk), .rst_n(rst_n), .en(en_v[g]), .rdy(rdy), .abort(abort_v[g]), .err(err),
      .key(key_v[g][8*KB-1:0]),
      .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren), .s_rddata(s_rddata),
      .ct_addr(ct_addr), .ct_rddata(ct_rddata),
      .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
    );

    always @(posedge clk) begin
      s_rddata  <= s_mem[s_addr];
      ct_rddata <= ct_mem[g][ct_addr];
      if (s_wren) begin
        s_mem[s_addr] <= s_wrdata;
        s_writes <= s_writes + 1;
      end
      if (pt_wren) begin
        pt_mem[pt_addr] <= pt_wrdata;
        pt_writes <= pt_writes + 1;
      end
      if (s_wren && pt_wren) both_hi <= both_hi + 1;
    end
  end

  function automatic logic [7:0] pt_rd(input int g, input int a);
    case (g)
      0: return u[0].pt_mem[a];
      1: return u[1].pt_mem[a];
      default: return u[2].pt_mem[a];
    endcase
  endfunction

  function automatic logic rdy_rd(input int g);
    case (g)
      0: return u[0].rdy;
      1: return u[1].rdy;
      default: return u[2].rdy;
    endcase
  endfunction

  function automatic logic err_rd(input int g);
    case (g)
      0: return u[0].err;
      1: return u[1].err;
      default: return u[2].err;
    endcase
  endfunction

  function automatic int ptw_rd(input int g);
    case (g)
      0: return u[0].pt_writes;
      1: return u[1].pt_writes;
      default: return u[2].pt_writes;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse en, then count cycles until rdy returns (cycle 1 = first busy cycle).
  task automatic run(input int g, input int budget, output int cyc);
    en_v[g] = 1'b1;
    tick();
    en_v[g] = 1'b0;
    cyc = 1;
    while (!rdy_rd(g) && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  // Software RC4-drop[N] keystream for a 3-byte key; ks_exp[1..n].
  task automatic rc4_model(input logic [23:0] kk, input int drop, input int n);
    logic [7:0] s [256];
    logic [7:0] kb [3];
    logic [7:0] t;
    int ii, jj;
    kb[0] = kk[23:16]; kb[1] = kk[15:8]; kb[2] = kk[7:0];
    for (int x = 0; x < 256; x++) s[x] = 8'(x);
    jj = 0;
    for (int x = 0; x < 256; x++) begin
      jj = (jj + int'(s[x]) + int'(kb[x % 3])) % 256;
      t = s[x]; s[x] = s[jj]; s[jj] = t;
    end
    ii = 0; jj = 0;
    for (int x = 0; x < drop + n; x++) begin
      ii = (ii + 1) % 256;
      jj = (jj + int'(s[ii])) % 256;
      t = s[ii]; s[ii] = s[jj]; s[jj] = t;
      if (x >= drop) ks_exp[x - drop + 1] = s[(int'(s[ii]) + int'(s[jj])) % 256];
    end
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      key_v[g] = '0;
      for (int a = 0; a < 256; a++) ct_mem[g][a] = 8'h00;
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    for (int g = 0; g < 3; g++) begin
      check($sformatf("rst_rdy%0d", g), 32'(rdy_rd(g)), 32'd1);
      check($sformatf("rst_err%0d", g), 32'(err_rd(g)), 32'd0);
    end
    check("rst_s_wren", 32'(u[0].s_wren), 32'd0);
    check("rst_pt_wren", 32'(u[0].pt_wren), 32'd0);
    check("rst_s_addr", 32'(u[0].s_addr), 32'd0);
    check("rst_ct_addr", 32'(u[0].ct_addr), 32'd0);

    // Key "Key", ciphertext of "Plaintext"
    key_v[0] = 32'h004B6579;
    for (int a = 0; a < 10; a++) ct_mem[0][a] = ct31[a];
    p0 = ptw_rd(0);
    run(0, 3000, lat);
    check("k3_latency", 32'(lat), 32'd1337);
    for (int a = 0; a < 10; a++) check($sformatf("k3_pt%0d", a), 32'(pt_rd(0, a)), 32'(pt31[a]));
    check("k3_pt_writes", 32'(ptw_rd(0) - p0), 32'd10);
    check("k3_err", 32'(err_rd(0)), 32'd0);

    // Key "Wiki", ciphertext of "pedia"
    key_v[1] = 32'h57696B69;
    for (int a = 0; a < 6; a++) ct_mem[1][a] = ct32[a];
    run(1, 3000, lat);
    check("k4_latency", 32'(lat), 32'd1313);
    for (int a = 0; a < 6; a++) check($sformatf("k4_pt%0d", a), 32'(pt_rd(1, a)), 32'(pt32[a]));
    check("k4_err", 32'(err_rd(1)), 32'd0);

    // Zero-length message
    ct_mem[0][0] = 8'h00;
    p0 = ptw_rd(0);
    run(0, 3000, lat);
    check("l0_latency", 32'(lat), 32'd1283);
    check("l0_pt0", 32'(pt_rd(0, 0)), 32'd0);
    check("l0_pt_writes", 32'(ptw_rd(0) - p0), 32'd1);

    // Abort on cycle 500 (KSA write sub-cycle)
    ct_mem[0][0] = ct31[0];
    en_v[0] = 1'b1;
    tick();
    en_v[0] = 1'b0;
    cnt = 1;
    while (cnt < 500) begin tick(); cnt++; end
    abort_v[0] = 1'b1;
    s0 = u[0].s_writes;
    p0 = ptw_rd(0);
    tick();
    abort_v[0] = 1'b0;
    check("ab_rdy", 32'(rdy_rd(0)), 32'd1);
    check("ab_err", 32'(err_rd(0)), 32'd1);
    check("ab_s_writes", 32'(u[0].s_writes - s0), 32'd0);
    repeat (20) tick();
    check("ab_s_writes_later", 32'(u[0].s_writes - s0), 32'd0);
    check("ab_pt_writes_later", 32'(ptw_rd(0) - p0), 32'd0);

    // en and abort together in IDLE: no start, err kept
    en_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    tick();
    en_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    tick();
    check("enab_rdy", 32'(rdy_rd(0)), 32'd1);
    check("enab_err", 32'(err_rd(0)), 32'd1);

    // Restart after abort
    p0 = ptw_rd(0);
    run(0, 3000, lat);
    check("rerun_latency", 32'(lat), 32'd1337);
    check("rerun_err", 32'(err_rd(0)), 32'd0);
    check("rerun_pt_writes", 32'(ptw_rd(0) - p0), 32'd10);
    for (int a = 0; a < 10; a++) check($sformatf("rerun_pt%0d", a), 32'(pt_rd(0, a)), 32'(pt31[a]));

    // en pulsed during PRGA is ignored
    p0 = ptw_rd(0);
    en_v[0] = 1'b1;
    tick();
    en_v[0] = 1'b0;
    cnt = 1;
    while (cnt < 1300) begin tick(); cnt++; end
    en_v[0] = 1'b1;
    tick();
    en_v[0] = 1'b0;
    cnt++;
    while (!rdy_rd(0) && cnt < 3000) begin tick(); cnt++; end
    check("enbusy_latency", 32'(cnt), 32'd1337);
    check("enbusy_pt_writes", 32'(ptw_rd(0) - p0), 32'd10);
    repeat (5) tick();
    check("enbusy_idle", 32'(rdy_rd(0)), 32'd1);
    check("enbusy_no_restart", 32'(ptw_rd(0) - p0), 32'd10);

    // Reset for one cycle mid-INIT
    en_v[0] = 1'b1;
    tick();
    en_v[0] = 1'b0;
    cnt = 1;
    while (cnt < 100) begin tick(); cnt++; end
    rst_n = 1'b0;
    #1;
    check("midrst_s_wren", 32'(u[0].s_wren), 32'd0);
    check("midrst_s_addr", 32'(u[0].s_addr), 32'd0);
    check("midrst_s_wrdata", 32'(u[0].s_wrdata), 32'd0);
    tick();
    rst_n = 1'b1;
    s0 = u[0].s_writes;
    check("midrst_rdy", 32'(rdy_rd(0)), 32'd1);
    check("midrst_err", 32'(err_rd(0)), 32'd0);
    check("midrst_pt_wren", 32'(u[0].pt_wren), 32'd0);
    repeat (10) tick();
    check("midrst_no_resume", 32'(u[0].s_writes - s0), 32'd0);
    check("midrst_rdy_later", 32'(rdy_rd(0)), 32'd1);

    // RC4-drop[256]
    key_v[2] = 32'h004B6579;
    for (int a = 0; a < 10; a++) ct_mem[2][a] = ct31[a];
    rc4_model(24'h4B6579, 256, 9);
    run(2, 4000, lat);
    check("drop_latency", 32'(lat), 32'd2617);
    check("drop_pt0", 32'(pt_rd(2, 0)), 32'h09);
    for (int a = 1; a < 10; a++)
      check($sformatf("drop_pt%0d", a), 32'(pt_rd(2, a)), 32'(ct31[a] ^ ks_exp[a]));

    // Never both write enables in one cycle
    check("both_wren0", 32'(u[0].both_hi), 32'd0);
    check("both_wren1", 32'(u[1].both_hi), 32'd0);
    check("both_wren2", 32'(u[2].both_hi), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arc4_engine.md
ARC4_ENGINE -- requirements
Module: arc4_engine

Interface
REQ-001 Parameter KEY_BYTES, default 3, key length in bytes, legal range 1..32.
REQ-002 Parameter DROP_N, default 0, keystream bytes discarded before decryption (RC4-drop[N]), legal range 0..1023.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  start request; sampled only while rdy=1.
REQ-006 rdy  output  1  high only in IDLE.
REQ-007 abort  input  1  terminate the current run.
REQ-008 err  output  1  sticky flag: last run was aborted.
REQ-009 key  input  8*KEY_BYTES  key; byte 0 = key[8*KEY_BYTES-1 -: 8]; sampled only on the cycle en is accepted.
REQ-010 s_addr / s_wrdata / s_wren  output  8/8/1  S-box RAM port, 256x8.
REQ-011 s_rddata  input  8  S-box read data, valid one cycle after s_addr is presented.
REQ-012 ct_addr  output  8; ct_rddata  input  8  ciphertext RAM, 1-cycle read latency; ct[0] = length L, ct[1..L] = data.
REQ-013 pt_addr / pt_wrdata / pt_wren  output  8/8/1  plaintext RAM write port; pt[0] = L, pt[1..L] = data.

Function
REQ-014 States: IDLE, INIT, KSA, LEN, DROP, PRGA; no other reachable state; illegal encodings go to IDLE.
REQ-015 IDLE: no memory writes; en=1 with abort=0 latches key, clears err, enters INIT next cycle.
REQ-016 INIT: 256 cycles; cycle n writes s[n]=n, n=0..255; then KSA.
REQ-017 KSA: i=0..255, j starts at 0, 4 cycles per i: (a) s_addr=i; (b) capture si, j=(j+si+key byte[i mod KEY_BYTES]) mod 256, s_addr=j; (c) capture sj, write s[j]=si; (d) write s[i]=sj.
REQ-018 KSA lasts exactly 1024 cycles, then LEN with i=0, j=0.
REQ-019 LEN: 2 cycles; ct_addr=0, then capture L and write pt[0]=L.
REQ-020 DROP: DROP_N iterations of 5 cycles: i=i+1; read s[i]; j=j+si; read s[j]; write s[j]=si; write s[i]=sj; read s[(si+sj) mod 256]; no pt write.
REQ-021 PRGA: k=1..L, 6 cycles each; same 5 cycles as DROP with ct_addr=k held, then a 6th cycle writing pt[k]=pad XOR ct[k].
REQ-022 i, j, k and all index sums wrap modulo 256; i and j continue unbroken from DROP into PRGA.
REQ-023 L=0: LEN is followed by DROP (if DROP_N>0), then IDLE; no pt write other than pt[0].
REQ-024 rdy reasserts exactly 1283 + 5*DROP_N + 6*L cycles after the en-accept cycle.
REQ-025 s_wren and pt_wren are never high in the same cycle; write addresses and data are valid whenever the corresponding wren is high.
REQ-026 en while rdy=0 is ignored; changes on key while busy have no effect.
REQ-027 abort=1 in any non-IDLE state: IDLE on the next cycle, no writes in that cycle or after, err=1.
REQ-028 en and abort both high in IDLE: abort wins; no start, err unchanged.

Reset
REQ-029 rst_n=0 at any clock edge, mid-run included: state IDLE, i=j=k=0, err=0, s_wren=pt_wren=0, all addresses and data outputs 0; rdy=1 on the first cycle after release.
REQ-030 A run cut short by reset is not resumed; RAM contents are left as-is.

Verification
REQ-031 KEY_BYTES=3, key=24'h4B6579, DROP_N=0, ct={09,BB,F3,16,E8,D9,40,AF,0A,D3} -> pt={09,50,6C,61,69,6E,74,65,78,74}; rdy after 1337 cycles.
REQ-032 KEY_BYTES=4, key=32'h57696B69, ct={05,10,21,BF,04,20} -> pt={05,70,65,64,69,61}; err=0.
REQ-033 L=0, DROP_N=0 -> only pt[0]=00 written; rdy after exactly 1283 cycles.
REQ-034 abort on cycle 500 (mid-KSA) -> no writes from cycle 501; rdy=1 and err=1 at cycle 501; next en clears err and the run produces the REQ-031 result.
REQ-035 en pulsed during PRGA, and rst_n low for 1 cycle mid-INIT -> en ignored, no extra writes; after reset rdy=1, err=0, outputs 0.
REQ-036 DROP_N=256 with the REQ-031 key -> pt matches the software RC4-drop[256] model; latency 1337+1280 cycles.
